// File: rtl/avg_stats_accum.sv
// Purpose: gathers sum/mean/max/min/count-above-threshold over one in-order 2^N-sample RAM write pass.
// Latency: statistics are visible the cycle after the accepting edge; mean and done follow the last sample by one edge.
// Backpressure: none; this block only snoops the write stream, and it drops and flags samples that arrive out of order.
module avg_stats_accum #(
    parameter int             W      = 8,
    parameter int             N      = 4,
    parameter logic [W-1:0]   THRESH = 8'h0F
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             wr_en,
    input  logic [N-1:0]     wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W+N-1:0]   result,
    output logic [W+N-1:0]   sum_out,
    output logic [N:0]       count_gt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [N:0] LAST_ENTRY = (N+1)'((1 << N) - 1);

    state_t          r_state;
    state_t          w_next;
    logic [W+N-1:0]  r_sum;
    logic [W-1:0]    r_mean;
    logic [W-1:0]    r_max;
    logic [W-1:0]    r_min;
    logic [N:0]      r_count;
    logic [N:0]      r_entries;
    logic [N-1:0]    r_exp_addr;
    logic            r_err;

    logic            w_sample;
    logic            w_accept;
    logic            w_drop;
    logic            w_last;

    // A write only counts while accumulating, and a coincident start always wins.
    assign w_sample = (r_state == S_ACCUM) && wr_en && !start;
    assign w_accept = w_sample && (wr_addr == r_exp_addr);
    assign w_drop   = w_sample && (wr_addr != r_exp_addr);
    assign w_last   = w_accept && (r_entries == LAST_ENTRY);

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start rearms from any state; FINISH lasts exactly one cycle.
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_ACCUM;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_ACCUM:  w_next = w_last ? S_FINISH : S_ACCUM;
                S_FINISH: w_next = S_DONE;
                S_DONE:   w_next = S_DONE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (r_state == S_ACCUM) || (r_state == S_FINISH);
        done = (r_state == S_DONE);
    end

    // Statistics datapath: clear on start, fold in accepted samples, latch mean during FINISH.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sum      <= '0;
            r_mean     <= '0;
            r_max      <= '0;
            r_min      <= '1;
            r_count    <= '0;
            r_entries  <= '0;
            r_exp_addr <= '0;
            r_err      <= 1'b0;
        end else if (start) begin
            r_sum      <= '0;
            r_mean     <= '0;
            r_max      <= '0;
            r_min      <= '1;
            r_count    <= '0;
            r_entries  <= '0;
            r_exp_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum      <= r_sum + (W+N)'(wr_data);
                r_max      <= (wr_data > r_max) ? wr_data : r_max;
                r_min      <= (wr_data < r_min) ? wr_data : r_min;
                r_count    <= (wr_data > THRESH) ? r_count + (N+1)'(1) : r_count;
                r_entries  <= r_entries + (N+1)'(1);
                // Wraps to zero only on the final sample of a pass.
                r_exp_addr <= r_exp_addr + N'(1);
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
            if (r_state == S_FINISH) begin
                r_mean <= r_sum[W+N-1:N];
            end
        end
    end

    // Result mux for the display path.
    always_comb begin
        case (sel)
            2'd0:    result = {{N{1'b0}}, r_mean};
            2'd1:    result = {{N{1'b0}}, r_max};
            2'd2:    result = {{N{1'b0}}, r_min};
            default: result = {{(W-1){1'b0}}, r_count};
        endcase
    end

    assign sum_out  = r_sum;
    assign count_gt = r_count;
    assign err      = r_err;

endmodule

// File: tb/tb_avg_stats_accum.sv
// Bench for avg_stats_accum: directed passes plus randomized passes against a sample-list model.
// Inputs change 1 time unit after the rising edge; outputs are compared on every falling edge.
// The model keeps the accepted samples of the current pass and derives each statistic from that list.
module tb_avg_stats_accum;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] result;
    logic [11:0] sum_out;
    logic [4:0]  count_gt;

    int checks = 0;
    int errors = 0;

    avg_stats_accum #(.W(8), .N(4), .THRESH(8'h0F)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .sum_out  (sum_out),
        .count_gt (count_gt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int m_q[$];
    bit m_armed = 1'b0;
    bit m_fin   = 1'b0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;
    int m_mean  = 0;

    function automatic int f_sum();
        int s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s;
    endfunction

    function automatic int f_max();
        int v = 0;
        foreach (m_q[i]) if (m_q[i] > v) v = m_q[i];
        return v;
    endfunction

    function automatic int f_min();
        int v = 255;
        foreach (m_q[i]) if (m_q[i] < v) v = m_q[i];
        return v;
    endfunction

    function automatic int f_cnt();
        int c = 0;
        foreach (m_q[i]) if (m_q[i] > 15) c++;
        return c;
    endfunction

    function automatic int f_result(input int s);
        case (s)
            0:       return m_mean;
            1:       return f_max();
            2:       return f_min();
            default: return f_cnt();
        endcase
    endfunction

    always @(negedge clr_n) begin
        m_q.delete();
        m_armed = 1'b0;
        m_fin   = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_mean  = 0;
    end

    always @(posedge clk) begin
        if (clr_n === 1'b1) begin
            if (start) begin
                m_q.delete();
                m_armed = 1'b1;
                m_fin   = 1'b0;
                m_done  = 1'b0;
                m_err   = 1'b0;
                m_mean  = 0;
            end else if (m_armed) begin
                if (wr_en) begin
                    if (int'(wr_addr) == m_q.size()) begin
                        m_q.push_back(int'(wr_data));
                        if (m_q.size() == 16) begin
                            m_armed = 1'b0;
                            m_fin   = 1'b1;
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_fin) begin
                m_fin  = 1'b0;
                m_done = 1'b1;
                m_mean = f_sum() / 16;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cmp_busy",   32'(busy),     32'(m_armed || m_fin));
        check("cmp_done",   32'(done),     32'(m_done));
        check("cmp_err",    32'(err),      32'(m_err));
        check("cmp_sum",    32'(sum_out),  32'(f_sum()));
        check("cmp_cnt",    32'(count_gt), 32'(f_cnt()));
        check("cmp_result", 32'(result),   32'(f_result(int'(sel))));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit st, input bit we, input int a, input int d);
        start   = st;
        wr_en   = we;
        wr_addr = a[3:0];
        wr_data = d[7:0];
        sel     = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic check_sel(input string nm, input int e0, input int e1, input int e2, input int e3);
        int exp_v[4];
        exp_v = '{e0, e1, e2, e3};
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check(nm, 32'(result), 32'(exp_v[s]));
        end
    endtask

    task automatic random_pass(input int tag);
        int e;
        int r;
        drive(1'b1, 1'b0, 0, 0);
        for (int c = 0; c < 400 && m_armed; c++) begin
            e = m_q.size();
            r = $urandom_range(0, 99);
            if (r < 15)
                drive(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 255));
            else if (r < 25)
                drive(1'b0, 1'b1, (e + 1 + $urandom_range(0, 14)) % 16, $urandom_range(0, 255));
            else if (r < 35)
                drive(1'b0, 1'b1, e, ($urandom_range(0, 1) != 0) ? 255 : 0);
            else
                drive(1'b0, 1'b1, e, $urandom_range(0, 255));
        end
        check("rnd_pass_complete", 32'(m_fin), 32'd1);
        drive(1'b0, 1'b0, 0, 0);
        check("rnd_done", 32'(done), 32'd1);
        for (int c = 0; c < 3; c++)
            drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
        check("rnd_hold_done", 32'(done), 32'd1);
    endtask

    initial begin
        int s5;
        clr_n   = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        sel     = 2'd2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_sum",  32'(sum_out), 32'd0);
        check("rst_min",  32'(result), 32'hFF);
        clr_n = 1'b1;

        // Writes in IDLE are ignored
        for (int i = 0; i < 6; i++)
            drive(1'b0, 1'b1, i, 8'h40 + i);
        check("idle_sum", 32'(sum_out), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full pass with data = 2*addr
        drive(1'b1, 1'b0, 0, 0);
        for (int a = 0; a < 16; a++) begin
            if (a == 7) drive(1'b0, 1'b0, 0, 0);
            drive(1'b0, 1'b1, a, 2 * a);
        end
        check("full_done_k",  32'(done), 32'd0);
        check("full_busy_k",  32'(busy), 32'd1);
        drive(1'b0, 1'b0, 0, 0);
        check("full_done_k1", 32'(done), 32'd1);
        check("full_sum", 32'(sum_out), 32'd240);
        check("full_cnt", 32'(count_gt), 32'd8);
        check_sel("full_sel", 15, 30, 0, 8);

        // Saturation: all 0xFF
        drive(1'b1, 1'b0, 0, 0);
        for (int a = 0; a < 16; a++)
            drive(1'b0, 1'b1, a, 255);
        drive(1'b0, 1'b0, 0, 0);
        check("sat_sum", 32'(sum_out), 32'hFF0);
        check("sat_cnt", 32'(count_gt), 32'd16);
        check_sel("sat_sel", 255, 255, 255, 16);

        // Out-of-order write
        drive(1'b1, 1'b0, 0, 0);
        s5 = 0;
        for (int a = 0; a < 5; a++) begin
            drive(1'b0, 1'b1, a, 10 + a);
            s5 += 10 + a;
        end
        drive(1'b0, 1'b1, 6, 99);
        check("ooo_err",  32'(err), 32'd1);
        check("ooo_sum",  32'(sum_out), 32'(s5));
        check("ooo_busy", 32'(busy), 32'd1);
        for (int a = 5; a < 16; a++)
            drive(1'b0, 1'b1, a, 10 + a);
        drive(1'b0, 1'b0, 0, 0);
        check("ooo_done", 32'(done), 32'd1);
        check("ooo_err_sticky", 32'(err), 32'd1);

        // Restart mid-pass, start coincident with a write
        drive(1'b1, 1'b0, 0, 0);
        for (int a = 0; a < 9; a++)
            drive(1'b0, 1'b1, a, 50);
        drive(1'b0, 1'b1, 12, 50);
        check("rs_err_set", 32'(err), 32'd1);
        drive(1'b1, 1'b1, 9, 8'h80);
        check("rs_sum",  32'(sum_out), 32'd0);
        check("rs_err",  32'(err), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        for (int a = 0; a < 16; a++)
            drive(1'b0, 1'b1, a, 100 + a);
        drive(1'b0, 1'b0, 0, 0);
        check("rs_done", 32'(done), 32'd1);
        check("rs_sum_full", 32'(sum_out), 32'd1720);
        check_sel("rs_sel", 107, 115, 100, 16);

        // Asynchronous reset between edges mid-pass
        drive(1'b1, 1'b0, 0, 0);
        for (int a = 0; a < 7; a++)
            drive(1'b0, 1'b1, a, 20 + a);
        sel = 2'd2;
        #2;
        clr_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_sum",  32'(sum_out), 32'd0);
        check("ar_cnt",  32'(count_gt), 32'd0);
        check("ar_min",  32'(result), 32'hFF);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        for (int a = 0; a < 4; a++)
            drive(1'b0, 1'b1, a, 77);
        check("ar_needs_start", 32'(sum_out), 32'd0);

        // Randomized passes
        for (int p = 0; p < 12; p++)
            random_pass(p);

        // Abort a random pass part way, then finish one cleanly
        drive(1'b1, 1'b0, 0, 0);
        for (int a = 0; a < 5; a++)
            drive(1'b0, 1'b1, a, $urandom_range(0, 255));
        random_pass(99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
